rand_range_sampler: RTL and testbench

Downstream consumer of the 32-bit LFSR output word. It turns the raw pseudo-random stream into an unbiased integer in [0, bound) on request, using mask-and-reject sampling with a bounded retry count. A requester supplies a bound through a valid/ready request channel and receives the result on a valid/ready response channel. The bound-limited fallback keeps worst-case latency deterministic.

---
 rtl/rand_pkg.sv | 21 ++
 rtl/range_mask.sv | 31 +++
 rtl/rand_range_sampler.sv | 112 +++++++++++
 tb/tb_rand_range_sampler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rand_pkg
// Description : Shared types and default constants for the range sampler.
// Revision    : 1.0 - initial release
// ============================================================================
package rand_pkg;

    // Sampler FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Default retry budget and tries-counter width
    localparam int c_MAX_TRIES_DEF = 8;
    localparam int c_TRY_W_DEF     = 8;

endpackage
`default_nettype wire

// File: rtl/range_mask.sv
`default_nettype none
// ============================================================================
// Module      : range_mask
// Description : Combinational mask generator. Produces the smallest all-ones
//               value (2^k - 1) that covers bound-1; zero for bound <= 1.
// Revision    : 1.0 - initial release
// ============================================================================
module range_mask #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] bound,
    output logic [DATA_W-1:0] mask
);

    localparam int c_STAGES = $clog2(DATA_W);

    // Each stage ORs in a copy shifted by a doubling distance, so after
    // log2(DATA_W) stages every bit below the leading one is set.
    logic [DATA_W-1:0] w_smear [0:c_STAGES];

    assign w_smear[0] = bound - DATA_W'(1);

    for (genvar g = 0; g < c_STAGES; g++) begin : g_smear
        assign w_smear[g+1] = w_smear[g] | (w_smear[g] >> (1 << g));
    end

    // bound-1 underflows for bound 0, so degenerate bounds are forced to 0
    assign mask = (bound <= DATA_W'(1)) ? '0 : w_smear[c_STAGES];

endmodule
`default_nettype wire

// File: rtl/rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module      : rand_range_sampler
// Description : Turns a free-running LFSR word stream into an unbiased integer
//               in [0, bound) using mask-and-reject sampling. After MAX_TRIES
//               rejections the last candidate is folded into range by one
//               subtraction, which bounds worst-case latency.
// Revision    : 1.0 - initial release
// ============================================================================
module rand_range_sampler
    import rand_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_TRIES = c_MAX_TRIES_DEF,
    parameter int TRY_W     = c_TRY_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rnd_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_bound,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TRY_W-1:0]  rsp_tries,
    output logic              rsp_fallback
);

    state_t            r_state;
    logic [DATA_W-1:0] r_bound;
    logic [DATA_W-1:0] r_mask;
    logic [TRY_W-1:0]  r_try_cnt;
    logic [DATA_W-1:0] r_rsp_data;
    logic [TRY_W-1:0]  r_rsp_tries;
    logic              r_rsp_fallback;

    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_cand;
    logic [TRY_W-1:0]  w_try_next;

    range_mask #(
        .DATA_W (DATA_W)
    ) u_range_mask (
        .bound (req_bound),
        .mask  (w_mask)
    );

    assign w_cand     = rnd_in & r_mask;
    assign w_try_next = r_try_cnt + TRY_W'(1);

    // Ready only while idle and out of reset
    assign req_ready    = (r_state == IDLE) && rst_n;
    assign rsp_valid    = (r_state == RESP);
    assign rsp_data     = r_rsp_data;
    assign rsp_tries    = r_rsp_tries;
    assign rsp_fallback = r_rsp_fallback;

    // Request capture, one sample per cycle, response hold until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_bound        <= '0;
            r_mask         <= '0;
            r_try_cnt      <= '0;
            r_rsp_data     <= '0;
            r_rsp_tries    <= '0;
            r_rsp_fallback <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_bound   <= req_bound;
                        r_mask    <= w_mask;
                        r_try_cnt <= '0;
                        r_state   <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (r_bound <= DATA_W'(1)) begin
                        // Only 0 is a legal result; no randomness consumed
                        r_rsp_data     <= '0;
                        r_rsp_tries    <= TRY_W'(1);
                        r_rsp_fallback <= 1'b0;
                        r_state        <= RESP;
                    end else if (w_cand < r_bound) begin
                        r_rsp_data     <= w_cand;
                        r_rsp_tries    <= w_try_next;
                        r_rsp_fallback <= 1'b0;
                        r_state        <= RESP;
                    end else if (w_try_next == TRY_W'(MAX_TRIES)) begin
                        // mask < 2*bound, so one subtraction lands in range
                        r_rsp_data     <= w_cand - r_bound;
                        r_rsp_tries    <= TRY_W'(MAX_TRIES);
                        r_rsp_fallback <= 1'b1;
                        r_state        <= RESP;
                    end else begin
                        r_try_cnt <= w_try_next;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rand_range_sampler
// Description : Directed self-checking bench for rand_range_sampler with a
//               reference model of mask-and-reject sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rand_range_sampler;

    localparam int DATA_W    = 32;
    localparam int MAX_TRIES = 8;
    localparam int TRY_W     = 8;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] rnd_in;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_bound;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TRY_W-1:0]  rsp_tries;
    logic              rsp_fallback;

    int checks = 0;
    int errors = 0;

    // Model state: expected response of the request in flight
    logic        m_busy;
    logic [31:0] m_exp_data;
    logic [7:0]  m_exp_tries;
    logic        m_exp_fb;

    // Sample words presented on successive SAMPLE cycles
    logic [31:0] wv [MAX_TRIES];

    rand_range_sampler #(
        .DATA_W    (DATA_W),
        .MAX_TRIES (MAX_TRIES),
        .TRY_W     (TRY_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rnd_in       (rnd_in),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_bound    (req_bound),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tries    (rsp_tries),
        .rsp_fallback (rsp_fallback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Smallest 2^k-1 covering bound-1, by plain doubling
    function automatic longint unsigned model_mask(input longint unsigned b);
        longint unsigned m;
        m = 0;
        if (b <= 1) return 0;
        while (m < b - 1) m = m * 2 + 1;
        return m;
    endfunction

    // Reference result for a bound and the word sequence in wv
    task automatic model_sample(input longint unsigned b, output logic [31:0] d,
                                output logic [7:0] t, output logic f);
        longint unsigned m, c;
        d = 0; t = 1; f = 0;
        if (b <= 1) return;
        m = model_mask(b);
        for (int i = 0; i < MAX_TRIES; i++) begin
            c = longint'(wv[i]) & m;
            if (c < b) begin
                d = c[31:0]; t = 8'(i + 1); f = 0;
                return;
            end
            if (i == MAX_TRIES - 1) begin
                d = 32'(c - b); t = 8'(MAX_TRIES); f = 1;
            end
        end
    endtask

    // Per-cycle compare, just after each falling edge
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
            chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
            chk("rst_rsp_tries", {56'd0, rsp_tries}, 64'd0);
            chk("rst_rsp_fb", {63'd0, rsp_fallback}, 64'd0);
        end else if (!m_busy) begin
            chk("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
        end else if (rsp_valid) begin
            chk("cmp_rsp_data", {32'd0, rsp_data}, {32'd0, m_exp_data});
            chk("cmp_rsp_tries", {56'd0, rsp_tries}, {56'd0, m_exp_tries});
            chk("cmp_rsp_fb", {63'd0, rsp_fallback}, {63'd0, m_exp_fb});
        end
    end

    // One full transaction; lit_* are hand-computed expectations
    task automatic do_req(input logic [31:0] b, input int stall,
                          input logic [31:0] lit_d, input logic [7:0] lit_t, input logic lit_f);
        logic [31:0] ed; logic [7:0] et; logic ef;
        model_sample(longint'(b), ed, et, ef);
        chk("model_data", {32'd0, ed}, {32'd0, lit_d});
        chk("model_tries", {56'd0, et}, {56'd0, lit_t});
        chk("model_fb", {63'd0, ef}, {63'd0, lit_f});
        m_exp_data = ed; m_exp_tries = et; m_exp_fb = ef;
        @(negedge clk);
        chk("req_ready_before", {63'd0, req_ready}, 64'd1);
        m_busy = 1'b1;
        req_valid = 1'b1; req_bound = b;
        @(negedge clk);
        req_valid = 1'b0; req_bound = 32'hDEAD_BEEF;
        for (int i = 0; i < int'(et); i++) begin
            rnd_in = wv[i];
            chk("busy_no_valid", {63'd0, rsp_valid}, 64'd0);
            chk("busy_not_ready", {63'd0, req_ready}, 64'd0);
            @(negedge clk);
        end
        chk("latency_valid", {63'd0, rsp_valid}, 64'd1);
        chk("lit_data", {32'd0, rsp_data}, {32'd0, lit_d});
        chk("lit_tries", {56'd0, rsp_tries}, {56'd0, lit_t});
        chk("lit_fb", {63'd0, rsp_fallback}, {63'd0, lit_f});
        for (int s = 0; s < stall; s++) begin
            rnd_in = $urandom;
            req_valid = 1'b1; req_bound = 32'd5;
            chk("stall_valid", {63'd0, rsp_valid}, 64'd1);
            chk("stall_not_ready", {63'd0, req_ready}, 64'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_busy = 1'b0;
        chk("post_hs_valid", {63'd0, rsp_valid}, 64'd0);
        chk("post_hs_ready", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < MAX_TRIES; i++) wv[i] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rnd_in = '0; req_valid = 1'b0; req_bound = '0; rsp_ready = 1'b0;
        m_busy = 1'b0; m_exp_data = '0; m_exp_tries = '0; m_exp_fb = 1'b0;
        fill(32'h0);

        chk("model_mask_80000000", model_mask(64'h8000_0000), 64'h7FFF_FFFF);
        chk("model_mask_ffffffff", model_mask(64'hFFFF_FFFF), 64'hFFFF_FFFF);
        chk("model_mask_10", model_mask(64'd10), 64'hF);

        // Reset held three cycles
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);

        // First-try accept
        fill(32'h1234_5677);
        do_req(32'd10, 0, 32'd7, 8'd1, 1'b0);

        // Two rejections then accept
        fill(32'h0);
        wv[0] = 32'hABCD_000E; wv[1] = 32'h1111_111F; wv[2] = 32'h2222_2223;
        do_req(32'd10, 0, 32'd3, 8'd3, 1'b0);

        // Fallback after MAX_TRIES rejections: 12 - 10 = 2
        fill(32'h5555_555C);
        do_req(32'd10, 0, 32'd2, 8'd8, 1'b0 | 1'b1);

        // Degenerate bounds, second one with backpressure
        fill(32'hFFFF_FFFF);
        do_req(32'd0, 0, 32'd0, 8'd1, 1'b0);
        do_req(32'd1, 5, 32'd0, 8'd1, 1'b0);

        // Power-of-two and near boundaries
        fill(32'h0000_000F);
        do_req(32'd16, 0, 32'd15, 8'd1, 1'b0);
        fill(32'h0000_003F);
        do_req(32'd17, 2, 32'd14, 8'd8, 1'b1);
        fill(32'h0);
        wv[0] = 32'h3; wv[1] = 32'h7; wv[2] = 32'h1;
        do_req(32'd3, 0, 32'd1, 8'd3, 1'b0);
        fill(32'h8000_0005);
        do_req(32'h8000_0000, 0, 32'd5, 8'd1, 1'b0);
        fill(32'h0000_0042);
        wv[0] = 32'hFFFF_FFFF;
        do_req(32'hFFFF_FFFF, 0, 32'h42, 8'd2, 1'b0);

        // Reset in the middle of sampling aborts the request
        @(negedge clk);
        m_busy = 1'b1;
        req_valid = 1'b1; req_bound = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0; rnd_in = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_sampling", {63'd0, rsp_valid}, 64'd0);
        #2 rst_n = 1'b0; m_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {63'd0, req_ready}, 64'd1);
        chk("midrst_no_valid", {63'd0, rsp_valid}, 64'd0);

        // Normal operation after the abort
        fill(32'h0);
        wv[0] = 32'h0000_000B; wv[1] = 32'h0000_0004;
        do_req(32'd10, 1, 32'd4, 8'd2, 1'b0);

        repeat (2) @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
